// File: rtl/i2c_txn_arbiter.sv
// Two-requester round-robin front end for a single I2C master: grant, issue, wait, respond.
// Optional WAIT timeout is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_rw,
  input  logic [13:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        Master_en,
  output logic        R_W_en,
  output logic [6:0]  Mem_Addr,
  output logic [7:0]  Data,
  input  logic [7:0]  data_out,
  input  logic        done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        gnt_q, gnt_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  req_ready_q, req_ready_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        master_en_q, master_en_d;
  logic        gnt_sel;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_err_q, rsp_err_d;
  logic             tmo_hit;

  // Counter holds the number of WAIT cycles already completed.
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Single requester wins outright; contention is resolved by rr_ptr.
  assign gnt_sel = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    master_en_d = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gnt_d       = gnt_sel;
          rr_ptr_d    = ~gnt_sel;
          rw_d        = req_rw[gnt_sel];
          addr_d      = gnt_sel ? req_addr[13:7] : req_addr[6:0];
          wdata_d     = gnt_sel ? req_wdata[15:8] : req_wdata[7:0];
          req_ready_d = gnt_sel ? 2'b10 : 2'b01;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        master_en_d = 1'b1;
        state_d     = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
        tmo_cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (done) begin
          rdata_d     = rw_q ? data_out : '0;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = RESP;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          rdata_d     = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = RESP;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      gnt_q       <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      master_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      master_en_q <= master_en_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != IDLE);
  assign Master_en = master_en_q;
  assign R_W_en    = rw_q;
  assign Mem_Addr  = addr_q;
  assign Data      = wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed, table-driven bench for i2c_txn_arbiter (default or I2C_ARB_TIMEOUT_EN build).
module tb_i2c_txn_arbiter;

  localparam int TB_TMO = 8;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int MAX_DLY = TB_TMO - 1;
`else
  localparam int MAX_DLY = 1000;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_rw;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        Master_en;
  logic        R_W_en;
  logic [6:0]  Mem_Addr;
  logic [7:0]  Data;
  logic [7:0]  data_out;
  logic        done;

  int checks = 0;
  int failures = 0;
  int men_cnt = 0;
  int rsp_cnt = 0;

  i2c_txn_arbiter #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .Master_en(Master_en), .R_W_en(R_W_en), .Mem_Addr(Mem_Addr), .Data(Data),
    .data_out(data_out), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Master_en) men_cnt++;
    if (rsp_valid != 2'b00) rsp_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  rw;
    logic [13:0] addr;
    logic [15:0] wdata;
    int          dly;
    logic [7:0]  dout;
    logic [1:0]  exp_ready;
    logic        exp_rw;
    logic [6:0]  exp_addr;
    logic [7:0]  exp_data;
    logic [7:0]  exp_rdata;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output logic [1:0] got);
    got = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      if (req_ready != 2'b00) begin
        got = req_ready;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] got;
    int d;
    int m0;
    m0 = men_cnt;
    req_valid = v.valid;
    req_rw    = v.rw;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    wait_ready(got);
    chk({tag, ".req_ready"}, 32'(got), 32'(v.exp_ready));
    // Scramble request fields: only the grant-cycle values may be used.
    req_valid = 2'b00;
    req_rw    = ~v.rw;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    step();
    chk({tag, ".master_en"}, 32'(Master_en), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".r_w_en"}, 32'(R_W_en), 32'(v.exp_rw));
    chk({tag, ".mem_addr"}, 32'(Mem_Addr), 32'(v.exp_addr));
    chk({tag, ".data"}, 32'(Data), 32'(v.exp_data));
    d = (v.dly > MAX_DLY) ? MAX_DLY : v.dly;
    repeat (d) step();
    data_out = v.dout;
    done = 1'b1;
    step();
    done = 1'b0;
    data_out = 8'hEE;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v.exp_ready));
    chk({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, ".r_w_en_held"}, 32'(R_W_en), 32'(v.exp_rw));
    chk({tag, ".mem_addr_held"}, 32'(Mem_Addr), 32'(v.exp_addr));
    chk({tag, ".data_held"}, 32'(Data), 32'(v.exp_data));
    chk({tag, ".master_en_pulses"}, 32'(men_cnt - m0), 32'd1);
    step();
    chk({tag, ".rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  vec_t tbl[6];
  vec_t post_rst;

  initial begin
    logic [1:0] got;
    logic [1:0] exp_order[4];
    int r0;
    int k;

    tbl[0] = '{2'b01, 2'b00, {7'h00, 7'h55}, {8'h00, 8'h55}, 23, 8'hFF, 2'b01, 1'b0, 7'h55, 8'h55, 8'h00};
    tbl[1] = '{2'b10, 2'b10, {7'h01, 7'h7F}, {8'h3C, 8'h00}, 2, 8'hA5, 2'b10, 1'b1, 7'h01, 8'h3C, 8'hA5};
    tbl[2] = '{2'b11, 2'b01, {7'h22, 7'h11}, {8'hBB, 8'hAA}, 0, 8'h5A, 2'b01, 1'b1, 7'h11, 8'hAA, 8'h5A};
    tbl[3] = '{2'b11, 2'b01, {7'h22, 7'h11}, {8'hBB, 8'hAA}, 1, 8'h77, 2'b10, 1'b0, 7'h22, 8'hBB, 8'h00};
    tbl[4] = '{2'b10, 2'b10, {7'h7F, 7'h00}, {8'hFF, 8'h00}, 3, 8'hC3, 2'b10, 1'b1, 7'h7F, 8'hFF, 8'hC3};
    tbl[5] = '{2'b11, 2'b11, {7'h40, 7'h3F}, {8'h12, 8'h34}, 4, 8'h81, 2'b01, 1'b1, 7'h3F, 8'h34, 8'h81};
    post_rst = '{2'b11, 2'b10, {7'h0A, 7'h0B}, {8'hC0, 8'h0C}, 1, 8'h44, 2'b01, 1'b0, 7'h0B, 8'h0C, 8'h00};
    exp_order[0] = 2'b01;
    exp_order[1] = 2'b10;
    exp_order[2] = 2'b01;
    exp_order[3] = 2'b10;

    // Reset with both requesters already asserting.
    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_rw    = 2'b00;
    req_addr  = {7'h01, 7'h02};
    req_wdata = {8'h10, 8'h20};
    data_out  = 8'hFF;
    done      = 1'b1;
    step();
    step();
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.master_en", 32'(Master_en), 32'd0);
    chk("rst.r_w_en", 32'(R_W_en), 32'd0);
    chk("rst.mem_addr", 32'(Mem_Addr), 32'd0);
    chk("rst.data", 32'(Data), 32'd0);
    done = 1'b0;
    reset_n = 1'b1;

    // Both requesters held valid across four transactions.
    for (int t = 0; t < 4; t++) begin
      wait_ready(got);
      chk($sformatf("rr%0d.grant", t), 32'(got), 32'(exp_order[t]));
      step();
      chk($sformatf("rr%0d.master_en", t), 32'(Master_en), 32'd1);
      done = 1'b1;
      step();
      done = 1'b0;
      chk($sformatf("rr%0d.rsp_valid", t), 32'(rsp_valid), 32'(exp_order[t]));
      chk($sformatf("rr%0d.ready_in_resp", t), 32'(req_ready), 32'd0);
      chk($sformatf("rr%0d.rsp_rdata", t), 32'(rsp_rdata), 32'd0);
    end
    req_valid = 2'b00;
    step();
    step();
    chk("rr.final_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // done pulses in IDLE and ISSUE must be ignored.
    r0 = rsp_cnt;
    done = 1'b1;
    step();
    chk("ign.idle_busy", 32'(busy), 32'd0);
    req_valid = 2'b01;
    req_rw    = 2'b01;
    req_addr  = {7'h00, 7'h33};
    req_wdata = {8'h00, 8'h66};
    data_out  = 8'h99;
    wait_ready(got);
    chk("ign.req_ready", 32'(got), 32'd1);
    req_valid = 2'b00;
    step();
    done = 1'b0;
    chk("ign.master_en", 32'(Master_en), 32'd1);
    chk("ign.no_rsp_w1", 32'(rsp_valid), 32'd0);
    step();
    step();
    chk("ign.still_busy", 32'(busy), 32'd1);
    chk("ign.rsp_count", 32'(rsp_cnt - r0), 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("ign.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ign.rsp_rdata", 32'(rsp_rdata), 32'h99);
    step();

    // Reset while waiting on the master.
    req_valid = 2'b10;
    req_rw    = 2'b10;
    req_addr  = {7'h2A, 7'h00};
    req_wdata = {8'h5C, 8'h00};
    wait_ready(got);
    chk("mrst.req_ready", 32'(got), 32'd2);
    req_valid = 2'b00;
    step();
    step();
    step();
    r0 = rsp_cnt;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst.mem_addr", 32'(Mem_Addr), 32'd0);
    chk("mrst.data", 32'(Data), 32'd0);
    done = 1'b1;
    data_out = 8'h11;
    step();
    done = 1'b0;
    step();
    chk("mrst.rsp_count", 32'(rsp_cnt - r0), 32'd0);
    chk("mrst.idle_busy", 32'(busy), 32'd0);
    run_vec(post_rst, "post_rst");

    // Master never completes.
    req_valid = 2'b01;
    req_rw    = 2'b01;
    req_addr  = {7'h00, 7'h0F};
    req_wdata = {8'h00, 8'h21};
    data_out  = 8'h66;
    wait_ready(got);
    chk("tmo.req_ready", 32'(got), 32'd1);
    req_valid = 2'b00;
    step();
    chk("tmo.master_en", 32'(Master_en), 32'd1);
`ifdef I2C_ARB_TIMEOUT_EN
    k = 0;
    while (k < 20 && rsp_valid == 2'b00) begin
      step();
      k++;
    end
    chk("tmo.cycles", 32'(k), 32'(TB_TMO));
    chk("tmo.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tmo.rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo.rsp_rdata", 32'(rsp_rdata), 32'd0);
    step();
    chk("tmo.err_drop", 32'(rsp_err), 32'd0);
    chk("tmo.idle_busy", 32'(busy), 32'd0);
    // done arriving on the same cycle as the limit takes priority.
    run_vec('{2'b01, 2'b01, {7'h00, 7'h0E}, {8'h00, 8'h42}, TB_TMO - 1, 8'h99,
              2'b01, 1'b1, 7'h0E, 8'h42, 8'h99}, "tmo_tie");
`else
    r0 = rsp_cnt;
    k = 0;
    repeat (40) begin
      step();
      k++;
    end
    chk("notmo.busy", 32'(busy), 32'd1);
    chk("notmo.rsp_count", 32'(rsp_cnt - r0), 32'd0);
    chk("notmo.rsp_err", 32'(rsp_err), 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("notmo.late_rsp", 32'(rsp_valid), 32'd1);
    chk("notmo.late_rdata", 32'(rsp_rdata), 32'h66);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
